// File: rtl/itch_pkg.sv
// ----------------------------------------------------------------------------
// itch_pkg
// Types and constants for the ITCH-style message format. The inbound parser
// and the outbound order-message builder both use this package.
//   msg_t / TYPE_*   : decoded message kind and its type byte on the wire
//   trade_t          : BUY/SELL side of an ADD
//   stock_t / SYM_*  : known symbols and their raw 8-byte space-padded ids
//   ADD_LEN/SHORT_LEN: message lengths in bytes, type byte included
// ----------------------------------------------------------------------------
package itch_pkg;

  typedef enum logic [1:0] {
    MSG_ADD     = 2'd0,
    MSG_CANCEL  = 2'd1,
    MSG_EXECUTE = 2'd2
  } msg_t;

  localparam logic [7:0] TYPE_ADD     = 8'h0A;
  localparam logic [7:0] TYPE_CANCEL  = 8'h0C;
  localparam logic [7:0] TYPE_EXECUTE = 8'h0E;

  typedef enum logic {
    BUY  = 1'b0,
    SELL = 1'b1
  } trade_t;

  typedef enum logic [1:0] {
    AAPL  = 2'd0,
    AMZN  = 2'd1,
    GOOGL = 2'd2,
    MSFT  = 2'd3
  } stock_t;

  localparam logic [63:0] SYM_AAPL  = 64'h4141504C20202020;
  localparam logic [63:0] SYM_AMZN  = 64'h414D5A4E20202020;
  localparam logic [63:0] SYM_GOOGL = 64'h474F4F474C202020;
  localparam logic [63:0] SYM_MSFT  = 64'h4D53465420202020;

  localparam int ADD_LEN   = 26;
  localparam int SHORT_LEN = 13;

  function automatic logic type_known(input logic [7:0] b);
    return (b == TYPE_ADD) || (b == TYPE_CANCEL) || (b == TYPE_EXECUTE);
  endfunction

  // Only meaningful when type_known(b) is true.
  function automatic msg_t type_decode(input logic [7:0] b);
    case (b)
      TYPE_CANCEL:  return MSG_CANCEL;
      TYPE_EXECUTE: return MSG_EXECUTE;
      default:      return MSG_ADD;
    endcase
  endfunction

endpackage

// File: rtl/itch_parser_symbol_decoder.sv
// ----------------------------------------------------------------------------
// symbol_decoder
// Combinational lookup of a raw 8-byte stock id against the known symbols.
//   stock_id : raw big-endian symbol bytes
//   symbol   : matched symbol, AAPL (0) when nothing matches
//   hit      : stock_id matched one of the known symbols
// ----------------------------------------------------------------------------
module symbol_decoder
  import itch_pkg::*;
(
  input  logic [63:0] stock_id,
  output stock_t      symbol,
  output logic        hit
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise a latch is inferred.
    symbol = AAPL;
    hit    = 1'b0;
    case (stock_id)
      SYM_AAPL:  begin symbol = AAPL;  hit = 1'b1; end
      SYM_AMZN:  begin symbol = AMZN;  hit = 1'b1; end
      SYM_GOOGL: begin symbol = GOOGL; hit = 1'b1; end
      SYM_MSFT:  begin symbol = MSFT;  hit = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/itch_parser.sv
// ----------------------------------------------------------------------------
// itch_parser
// Deserialises a byte-serial ITCH-style stream (ADD / CANCEL / EXECUTE,
// big-endian fields) and presents each good message as one registered record.
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_data/i_valid/i_last  : stream byte, byte strobe, last-byte marker
//   o_msg_type .. o_price  : decoded fields, held between o_valid pulses
//   o_stock_symbol/_hit    : symbol lookup of o_stock_id
//   o_valid / o_error      : one-cycle pulses: good message / discarded one
// ----------------------------------------------------------------------------
module itch_parser
  import itch_pkg::*;
#(
  parameter int REG_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_data,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic [1:0]           o_msg_type,
  output logic [REG_WIDTH-1:0] o_timestamp,
  output logic [REG_WIDTH-1:0] o_order_id,
  output logic                 o_trade_type,
  output logic [REG_WIDTH-1:0] o_shares,
  output logic [63:0]          o_stock_id,
  output logic [1:0]           o_stock_symbol,
  output logic                 o_symbol_hit,
  output logic [REG_WIDTH-1:0] o_price,
  output logic                 o_valid,
  output logic                 o_error
);

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DRAIN} state_t;

  localparam logic [4:0] ADD_LAST   = 5'(ADD_LEN - 1);
  localparam logic [4:0] SHORT_LAST = 5'(SHORT_LEN - 1);

  state_t               state, state_nxt;
  logic [4:0]           cnt, cnt_nxt;
  msg_t                 cur_type, cur_type_nxt;
  logic [REG_WIDTH-1:0] sh_ts, sh_ts_nxt;
  logic [REG_WIDTH-1:0] sh_oid, sh_oid_nxt;
  logic [REG_WIDTH-1:0] sh_shares, sh_shares_nxt;
  logic [REG_WIDTH-1:0] sh_price, sh_price_nxt;
  trade_t               sh_side, sh_side_nxt;
  logic [63:0]          sh_stock, sh_stock_nxt;
  logic                 done_ok, done_err;
  logic [4:0]           last_idx;
  stock_t               dec_symbol;
  logic                 dec_hit;

  assign last_idx = (cur_type == MSG_ADD) ? ADD_LAST : SHORT_LAST;

  // The decoder looks at the next-state id so the lookup result is ready on
  // the same edge that completes the message.
  symbol_decoder u_symbol_decoder (
    .stock_id (sh_stock_nxt),
    .symbol   (dec_symbol),
    .hit      (dec_hit)
  );

  always_ff @(posedge i_clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic plus the shadow-register datapath. The counter indexes
  // the byte within the message; byte position selects the field to shift.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cur_type_nxt  = cur_type;
    sh_ts_nxt     = sh_ts;
    sh_oid_nxt    = sh_oid;
    sh_shares_nxt = sh_shares;
    sh_price_nxt  = sh_price;
    sh_side_nxt   = sh_side;
    sh_stock_nxt  = sh_stock;
    done_ok       = 1'b0;
    done_err      = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_valid) begin
          if (!type_known(i_data)) begin
            if (i_last) done_err  = 1'b1;
            else        state_nxt = S_DRAIN;
          end else if (i_last) begin
            // A known type byte cannot be a whole message.
            done_err = 1'b1;
          end else begin
            cur_type_nxt  = type_decode(i_data);
            cnt_nxt       = 5'd1;
            sh_ts_nxt     = '0;
            sh_oid_nxt    = '0;
            sh_shares_nxt = '0;
            sh_price_nxt  = '0;
            sh_side_nxt   = BUY;
            sh_stock_nxt  = '0;
            state_nxt     = S_BODY;
          end
        end
      end

      S_BODY: begin
        if (i_valid) begin
          if (cnt <= 5'd4)
            sh_ts_nxt = {sh_ts[REG_WIDTH-9:0], i_data};
          else if (cnt <= 5'd8)
            sh_oid_nxt = {sh_oid[REG_WIDTH-9:0], i_data};
          else if (cur_type != MSG_ADD)
            sh_shares_nxt = {sh_shares[REG_WIDTH-9:0], i_data};
          else if (cnt == 5'd9)
            sh_side_nxt = trade_t'(i_data[0]);
          else if (cnt <= 5'd13)
            sh_shares_nxt = {sh_shares[REG_WIDTH-9:0], i_data};
          else if (cnt <= 5'd21)
            sh_stock_nxt = {sh_stock[55:0], i_data};
          else
            sh_price_nxt = {sh_price[REG_WIDTH-9:0], i_data};

          cnt_nxt = cnt + 5'd1;
          if (cnt == last_idx) begin
            cnt_nxt = 5'd0;
            if (i_last) begin
              done_ok   = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_DRAIN;
            end
          end else if (i_last) begin
            cnt_nxt   = 5'd0;
            done_err  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end

      S_DRAIN: begin
        cnt_nxt = 5'd0;
        if (i_valid && i_last) begin
          done_err  = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt       <= 5'd0;
      cur_type  <= MSG_ADD;
      sh_ts     <= '0;
      sh_oid    <= '0;
      sh_shares <= '0;
      sh_price  <= '0;
      sh_side   <= BUY;
      sh_stock  <= '0;
    end else begin
      cnt       <= cnt_nxt;
      cur_type  <= cur_type_nxt;
      sh_ts     <= sh_ts_nxt;
      sh_oid    <= sh_oid_nxt;
      sh_shares <= sh_shares_nxt;
      sh_price  <= sh_price_nxt;
      sh_side   <= sh_side_nxt;
      sh_stock  <= sh_stock_nxt;
    end
  end

  // Output bank: loaded only on a good message; an error pulse leaves the
  // previous record in place.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_msg_type     <= '0;
      o_timestamp    <= '0;
      o_order_id     <= '0;
      o_trade_type   <= 1'b0;
      o_shares       <= '0;
      o_stock_id     <= '0;
      o_stock_symbol <= '0;
      o_symbol_hit   <= 1'b0;
      o_price        <= '0;
      o_valid        <= 1'b0;
      o_error        <= 1'b0;
    end else begin
      o_valid <= done_ok;
      o_error <= done_err;
      if (done_ok) begin
        o_msg_type  <= cur_type;
        o_timestamp <= sh_ts_nxt;
        o_order_id  <= sh_oid_nxt;
        o_shares    <= sh_shares_nxt;
        if (cur_type == MSG_ADD) begin
          o_trade_type   <= sh_side_nxt;
          o_stock_id     <= sh_stock_nxt;
          o_stock_symbol <= dec_symbol;
          o_symbol_hit   <= dec_hit;
          o_price        <= sh_price_nxt;
        end else begin
          o_trade_type   <= 1'b0;
          o_stock_id     <= '0;
          o_stock_symbol <= '0;
          o_symbol_hit   <= 1'b0;
          o_price        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_itch_parser.sv
// ----------------------------------------------------------------------------
// tb_itch_parser
// Scoreboard bench: each message's expected record (or error) is queued as the
// terminating byte is driven, tagged with the cycle it must appear in; a
// forked monitor pops and compares on every o_valid / o_error pulse.
// ----------------------------------------------------------------------------
module tb_itch_parser;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic [1:0]  o_msg_type;
  logic [31:0] o_timestamp, o_order_id, o_shares, o_price;
  logic        o_trade_type, o_symbol_hit, o_valid, o_error;
  logic [63:0] o_stock_id;
  logic [1:0]  o_stock_symbol;

  itch_parser #(.REG_WIDTH(32)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .i_last         (i_last),
    .o_msg_type     (o_msg_type),
    .o_timestamp    (o_timestamp),
    .o_order_id     (o_order_id),
    .o_trade_type   (o_trade_type),
    .o_shares       (o_shares),
    .o_stock_id     (o_stock_id),
    .o_stock_symbol (o_stock_symbol),
    .o_symbol_hit   (o_symbol_hit),
    .o_price        (o_price),
    .o_valid        (o_valid),
    .o_error        (o_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [1:0]  mtype;
    logic [31:0] ts, oid, shares, price;
    logic        trade, hit;
    logic [63:0] stock;
    logic [1:0]  sym;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [7:0] msg[$];
  int         n_vec = 0;
  int         n_miss = 0;

  // Reference decode of the bytes in msg, straight from the message layouts.
  function automatic exp_t model();
    exp_t e;
    e = '{err: 1'b0, mtype: 2'd0, ts: '0, oid: '0, shares: '0, price: '0,
          trade: 1'b0, hit: 1'b0, stock: '0, sym: 2'd0, cyc: 0};
    e.mtype = (msg[0] == 8'h0C) ? 2'd1 : (msg[0] == 8'h0E) ? 2'd2 : 2'd0;
    for (int i = 1; i <= 4; i++) e.ts  = {e.ts[23:0],  msg[i]};
    for (int i = 5; i <= 8; i++) e.oid = {e.oid[23:0], msg[i]};
    if (msg[0] == 8'h0A) begin
      e.trade = msg[9][0];
      for (int i = 10; i <= 13; i++) e.shares = {e.shares[23:0], msg[i]};
      for (int i = 14; i <= 21; i++) e.stock  = {e.stock[55:0],  msg[i]};
      for (int i = 22; i <= 25; i++) e.price  = {e.price[23:0],  msg[i]};
      case (e.stock)
        64'h4141504C20202020: begin e.sym = 2'd0; e.hit = 1'b1; end
        64'h414D5A4E20202020: begin e.sym = 2'd1; e.hit = 1'b1; end
        64'h474F4F474C202020: begin e.sym = 2'd2; e.hit = 1'b1; end
        64'h4D53465420202020: begin e.sym = 2'd3; e.hit = 1'b1; end
        default:              begin e.sym = 2'd0; e.hit = 1'b0; end
      endcase
    end else begin
      for (int i = 9; i <= 12; i++) e.shares = {e.shares[23:0], msg[i]};
    end
    return e;
  endfunction

  task automatic put32(input logic [31:0] v);
    for (int i = 3; i >= 0; i--) msg.push_back(v[i*8 +: 8]);
  endtask

  task automatic build_add(input logic [31:0] ts, input logic [31:0] oid,
                           input logic [7:0] side, input logic [31:0] shares,
                           input logic [63:0] stock, input logic [31:0] price);
    msg.delete();
    msg.push_back(8'h0A);
    put32(ts); put32(oid);
    msg.push_back(side);
    put32(shares);
    for (int i = 7; i >= 0; i--) msg.push_back(stock[i*8 +: 8]);
    put32(price);
  endtask

  task automatic build_short(input logic [7:0] typ, input logic [31:0] ts,
                             input logic [31:0] oid, input logic [31:0] shares);
    msg.delete();
    msg.push_back(typ);
    put32(ts); put32(oid); put32(shares);
  endtask

  // Drives the first n bytes of msg; i_last on byte last_idx (-1: never).
  // kind: 0 no pulse expected, 1 o_valid, 2 o_error. Leaves i_valid high
  // after the final byte so a following call streams with zero gap.
  task automatic send_msg(input int n, input int last_idx, input bit gaps,
                          input int kind);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          i_valid = 1'b0; i_last = 1'b0; i_data = 8'hXX;
        end
      end
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = msg[i];
      i_last  = (i == last_idx);
      if (i == n - 1 && kind != 0) begin
        e     = (kind == 1) ? model() : cur;
        e.err = (kind == 2);
        e.cyc = cyc + 1;
        if (kind == 1) cur = e;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_idle();
    @(negedge clk);
    i_valid = 1'b0; i_last = 1'b0;
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL pulse_timeout: %0d expected pulses never seen, required 0 outstanding", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if ({o_msg_type, o_timestamp, o_order_id, o_trade_type, o_shares, o_stock_id,
         o_stock_symbol, o_symbol_hit, o_price} !== '0) begin
      n_miss++;
      $display("FAIL %s_fields: ts=%h oid=%h sh=%h stk=%h pr=%h, required all 0",
               tag, o_timestamp, o_order_id, o_shares, o_stock_id, o_price);
    end
    n_vec++;
    if ({o_valid, o_error} !== 2'b00) begin
      n_miss++;
      $display("FAIL %s_pulses: valid=%b error=%b, required 0 0", tag, o_valid, o_error);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (o_valid === 1'b1 || o_error === 1'b1) begin
        n_vec++;
        if (o_valid === 1'b1 && o_error === 1'b1) begin
          n_miss++;
          $display("FAIL both_pulses at cycle %0d: valid=1 error=1, required exclusive", cyc);
        end
        if (sb.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_pulse at cycle %0d: valid=%b error=%b, required none",
                   cyc, o_valid, o_error);
        end else begin
          e = sb.pop_front();
          if (o_error !== e.err || e.cyc != cyc) begin
            n_miss++;
            $display("FAIL pulse_kind: error=%b at cycle %0d, required error=%b at cycle %0d",
                     o_error, cyc, e.err, e.cyc);
          end
          n_vec++;
          if (o_msg_type !== e.mtype || o_timestamp !== e.ts || o_order_id !== e.oid) begin
            n_miss++;
            $display("FAIL hdr_fields: type=%0d ts=%h oid=%h, required type=%0d ts=%h oid=%h",
                     o_msg_type, o_timestamp, o_order_id, e.mtype, e.ts, e.oid);
          end
          n_vec++;
          if (o_trade_type !== e.trade || o_shares !== e.shares || o_price !== e.price) begin
            n_miss++;
            $display("FAIL order_fields: trade=%b sh=%h pr=%h, required trade=%b sh=%h pr=%h",
                     o_trade_type, o_shares, o_price, e.trade, e.shares, e.price);
          end
          n_vec++;
          if (o_stock_id !== e.stock || o_stock_symbol !== e.sym || o_symbol_hit !== e.hit) begin
            n_miss++;
            $display("FAIL symbol_fields: id=%h sym=%0d hit=%b, required id=%h sym=%0d hit=%b",
                     o_stock_id, o_stock_symbol, o_symbol_hit, e.stock, e.sym, e.hit);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    check_zero("reset");
    cur = '{err: 1'b0, mtype: 2'd0, ts: '0, oid: '0, shares: '0, price: '0,
            trade: 1'b0, hit: 1'b0, stock: '0, sym: 2'd0, cyc: 0};
  endtask

  task automatic test_add();
    build_add(32'h300, 32'h3BA, 8'h01, 32'h1BB, 64'h4141504C20202020, 32'hBABB);
    send_msg(26, 25, 1'b0, 1);
    wait_idle();
  endtask

  task automatic test_cancel_gaps();
    build_short(8'h0C, 32'h10, 32'h7, 32'h5);
    send_msg(13, 12, 1'b1, 1);
    wait_idle();
  endtask

  task automatic test_unknown();
    msg.delete();
    msg.push_back(8'h55);
    for (int i = 0; i < 4; i++) msg.push_back(8'(8'h11 * (i + 1)));
    send_msg(5, 4, 1'b0, 2);
    msg.delete();
    msg.push_back(8'h77);
    send_msg(1, 0, 1'b0, 2);
    build_add(32'hDEAD0001, 32'h42, 8'h00, 32'h64, 64'h414D5A4E20202020, 32'h12345678);
    send_msg(26, 25, 1'b1, 1);
    wait_idle();
  endtask

  task automatic test_bad_length();
    build_add(32'h1, 32'h2, 8'h01, 32'h3, 64'h4D53465420202020, 32'h4);
    send_msg(10, 9, 1'b0, 2);
    wait_idle();
    build_add(32'h5, 32'h6, 8'h00, 32'h7, 64'h474F4F474C202020, 32'h8);
    msg.push_back(8'hEE);
    send_msg(27, 26, 1'b0, 2);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    build_short(8'h0E, 32'hA0A0A0A0, 32'hFFFF0001, 32'h00000FA0);
    send_msg(13, 12, 1'b0, 1);
    build_add(32'h77, 32'h88, 8'h01, 32'h99, 64'h5A5A5A5A20202020, 32'hAA);
    send_msg(26, 25, 1'b0, 1);
    build_add(32'hCAFE, 32'hF00D, 8'h00, 32'h1, 64'h474F4F474C202020, 32'h2);
    send_msg(26, 25, 1'b0, 1);
    build_add(32'hC0, 32'hC1, 8'h01, 32'hC2, 64'h4D53465420202020, 32'hC3);
    send_msg(26, 25, 1'b0, 1);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    build_add(32'h11, 32'h22, 8'h01, 32'h33, 64'h4141504C20202020, 32'h44);
    send_msg(15, -1, 1'b0, 0);
    @(negedge clk);
    i_valid = 1'b0; i_last = 1'b0;
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check_zero("reset_mid");
    cur = '{err: 1'b0, mtype: 2'd0, ts: '0, oid: '0, shares: '0, price: '0,
            trade: 1'b0, hit: 1'b0, stock: '0, sym: 2'd0, cyc: 0};
    repeat (3) @(negedge clk);
    check_zero("reset_quiet");
    build_add(32'h55, 32'h66, 8'h00, 32'h77, 64'h414D5A4E20202020, 32'h88);
    send_msg(26, 25, 1'b0, 1);
    wait_idle();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_add();
    test_cancel_gaps();
    test_unknown();
    test_bad_length();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
